// File: rtl/rnn_mem_arb.sv
// Two-port (core / host) arbiter in front of a single registered memory port.
// Requests carrying sel==3'b100 are refused and flagged on err. Ties go
// round-robin, and a host burst lock is broken by a core starvation override.
// Each read returns to the port that issued it, two cycles after the grant.
module rnn_mem_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [2:0]  c_sel,
    input  logic [16:0] c_addr,
    input  logic [19:0] c_wdata,
    input  logic        h_req,
    input  logic        h_we,
    input  logic [2:0]  h_sel,
    input  logic [16:0] h_addr,
    input  logic [19:0] h_wdata,
    input  logic        h_lock,
    input  logic [19:0] mdata_r,
    output logic        c_gnt,
    output logic        h_gnt,
    output logic        c_rvalid,
    output logic        h_rvalid,
    output logic [19:0] c_rdata,
    output logic [19:0] h_rdata,
    output logic        err,
    output logic        mce,
    output logic        mwe,
    output logic [2:0]  msel,
    output logic [16:0] maddr,
    output logic [19:0] mdata_w
);

    localparam logic [2:0] SEL_IDLE = 3'b100;

    typedef enum logic {OWN_CORE, OWN_HOST} owner_t;
    typedef enum logic {ARB_OPEN, ARB_LOCKED} state_t;

    state_t     state;
    state_t     state_next;
    owner_t     last_winner;
    logic [3:0] starve_cnt;
    logic       rd_pend;
    owner_t     rd_owner;
    logic       c_valid;
    logic       h_valid;

    assign c_valid = c_req && (c_sel != SEL_IDLE);
    assign h_valid = h_req && (h_sel != SEL_IDLE);

    // Lock state register: the host burst lock.
    always_ff @(posedge clk) begin
        if (reset) state <= ARB_OPEN;
        else       state <= state_next;
    end

    // Grant decision, error flag and lock transitions. All outputs are forced low during reset.
    always_comb begin
        c_gnt      = 1'b0;
        h_gnt      = 1'b0;
        err        = 1'b0;
        state_next = state;
        if (!reset) begin
            err = (c_req && (c_sel == SEL_IDLE)) || (h_req && (h_sel == SEL_IDLE));
            if (c_valid && (starve_cnt == 4'hF)) begin
                c_gnt = 1'b1;
            end else if (state == ARB_LOCKED) begin
                h_gnt = h_valid;
            end else if (c_valid && h_valid) begin
                if (last_winner == OWN_HOST) c_gnt = 1'b1;
                else                         h_gnt = 1'b1;
            end else begin
                c_gnt = c_valid;
                h_gnt = h_valid;
            end
            case (state)
                ARB_OPEN:   if (h_gnt && h_lock)     state_next = ARB_LOCKED;
                ARB_LOCKED: if (!(h_req && h_lock))  state_next = ARB_OPEN;
                default:                             state_next = ARB_OPEN;
            endcase
        end
    end

    // Round-robin pointer and the core starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= OWN_HOST;
            starve_cnt  <= 4'd0;
        end else begin
            if (c_gnt)      last_winner <= OWN_CORE;
            else if (h_gnt) last_winner <= OWN_HOST;
            if (!c_req || c_gnt)        starve_cnt <= 4'd0;
            else if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Registered memory command. On idle cycles the address and data hold their last values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mce     <= 1'b0;
            mwe     <= 1'b0;
            msel    <= SEL_IDLE;
            maddr   <= 17'd0;
            mdata_w <= 20'd0;
        end else if (c_gnt) begin
            mce     <= 1'b1;
            mwe     <= c_we;
            msel    <= c_sel;
            maddr   <= c_addr;
            mdata_w <= c_wdata;
        end else if (h_gnt) begin
            mce     <= 1'b1;
            mwe     <= h_we;
            msel    <= h_sel;
            maddr   <= h_addr;
            mdata_w <= h_wdata;
        end else begin
            mce     <= 1'b0;
            mwe     <= 1'b0;
            msel    <= SEL_IDLE;
        end
    end

    // Read-return pipeline. The owner tag travels with the command, and the memory data is captured one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWN_CORE;
            c_rvalid <= 1'b0;
            h_rvalid <= 1'b0;
            c_rdata  <= 20'd0;
            h_rdata  <= 20'd0;
        end else begin
            rd_pend  <= (c_gnt && !c_we) || (h_gnt && !h_we);
            rd_owner <= h_gnt ? OWN_HOST : OWN_CORE;
            c_rvalid <= rd_pend && (rd_owner == OWN_CORE);
            h_rvalid <= rd_pend && (rd_owner == OWN_HOST);
            if (rd_pend && (rd_owner == OWN_CORE)) c_rdata <= mdata_r;
            if (rd_pend && (rd_owner == OWN_HOST)) h_rdata <= mdata_r;
        end
    end

endmodule

// File: tb/tb_rnn_mem_arb.sv
// Scoreboard bench for rnn_mem_arb. The stimulus side runs a cycle-level
// reference model and queues the expected grant, memory command and read
// return for each cycle. The monitor pops those entries and compares them
// with the DUT on the falling edge.
module tb_rnn_mem_arb;

    typedef struct {
        logic        reset;
        logic        c_req;
        logic        c_we;
        logic [2:0]  c_sel;
        logic [16:0] c_addr;
        logic [19:0] c_wdata;
        logic        h_req;
        logic        h_we;
        logic [2:0]  h_sel;
        logic [16:0] h_addr;
        logic [19:0] h_wdata;
        logic        h_lock;
        logic [19:0] mdata_r;
    } stim_t;

    typedef struct {
        int          cyc;
        logic [41:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, h_req, h_we, h_lock;
    logic [2:0]  c_sel, h_sel;
    logic [16:0] c_addr, h_addr;
    logic [19:0] c_wdata, h_wdata, mdata_r;
    logic        c_gnt, h_gnt, c_rvalid, h_rvalid, err, mce, mwe;
    logic [19:0] c_rdata, h_rdata, mdata_w;
    logic [2:0]  msel;
    logic [16:0] maddr;

    int cycle = 0;
    int total = 0;
    int bad   = 0;

    exp_t gnt_q[$];
    exp_t cmd_q[$];
    exp_t ret_q[$];

    // Reference model state, kept in plain behavioural terms
    bit          m_last_host;
    bit          m_lock;
    int          m_starve;
    logic [16:0] m_maddr;
    logic [19:0] m_mdata;
    logic [19:0] m_c_rdata, m_h_rdata;
    bit          m_pend;
    bit          m_pend_host;

    rnn_mem_arb dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_sel(c_sel), .c_addr(c_addr), .c_wdata(c_wdata),
        .h_req(h_req), .h_we(h_we), .h_sel(h_sel), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_lock(h_lock), .mdata_r(mdata_r),
        .c_gnt(c_gnt), .h_gnt(h_gnt), .c_rvalid(c_rvalid), .h_rvalid(h_rvalid),
        .c_rdata(c_rdata), .h_rdata(h_rdata), .err(err),
        .mce(mce), .mwe(mwe), .msel(msel), .maddr(maddr), .mdata_w(mdata_w)
    );

    // Free-running clock and cycle index
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic stim_t idle_stim();
        stim_t s;
        s.reset = 1'b0; s.c_req = 1'b0; s.c_we = 1'b0; s.c_sel = 3'b100;
        s.c_addr = '0; s.c_wdata = '0; s.h_req = 1'b0; s.h_we = 1'b0;
        s.h_sel = 3'b100; s.h_addr = '0; s.h_wdata = '0; s.h_lock = 1'b0;
        s.mdata_r = 20'($urandom);
        return s;
    endfunction

    task automatic push_exp(ref exp_t q[$], input int cyc, input logic [41:0] val);
        exp_t e;
        e.cyc = cyc;
        e.val = val;
        q.push_back(e);
    endtask

    // Drive one cycle of stimulus and queue what the spec says must follow
    task automatic apply_stimulus(input stim_t s);
        bit cv, hv, ev, gc, gh;
        bit rc, rh;
        logic [41:0] cmd;
        @(posedge clk);
        #1;
        reset = s.reset; c_req = s.c_req; c_we = s.c_we; c_sel = s.c_sel;
        c_addr = s.c_addr; c_wdata = s.c_wdata; h_req = s.h_req; h_we = s.h_we;
        h_sel = s.h_sel; h_addr = s.h_addr; h_wdata = s.h_wdata; h_lock = s.h_lock;
        mdata_r = s.mdata_r;
        gc = 0; gh = 0; ev = 0; rc = 0; rh = 0;
        if (s.reset) begin
            m_last_host = 1; m_lock = 0; m_starve = 0;
            m_maddr = '0; m_mdata = '0; m_c_rdata = '0; m_h_rdata = '0;
            m_pend = 0; m_pend_host = 0;
            cmd = {1'b0, 1'b0, 3'b100, 17'd0, 20'd0};
        end else begin
            cv = s.c_req && (s.c_sel != 3'b100);
            hv = s.h_req && (s.h_sel != 3'b100);
            ev = (s.c_req && (s.c_sel == 3'b100)) || (s.h_req && (s.h_sel == 3'b100));
            if (cv && m_starve == 15)  gc = 1;
            else if (m_lock)           gh = hv;
            else if (cv && hv)         begin gc = m_last_host; gh = !m_last_host; end
            else                       begin gc = cv; gh = hv; end
            if (!s.c_req || gc) m_starve = 0;
            else if (m_starve < 15) m_starve = m_starve + 1;
            m_lock = (gh && s.h_lock) || (m_lock && s.h_req && s.h_lock);
            if (gc) m_last_host = 0;
            if (gh) m_last_host = 1;
            if (gc) begin
                m_maddr = s.c_addr; m_mdata = s.c_wdata;
                cmd = {1'b1, s.c_we, s.c_sel, s.c_addr, s.c_wdata};
            end else if (gh) begin
                m_maddr = s.h_addr; m_mdata = s.h_wdata;
                cmd = {1'b1, s.h_we, s.h_sel, s.h_addr, s.h_wdata};
            end else begin
                cmd = {1'b0, 1'b0, 3'b100, m_maddr, m_mdata};
            end
            if (m_pend) begin
                if (m_pend_host) begin rh = 1; m_h_rdata = s.mdata_r; end
                else             begin rc = 1; m_c_rdata = s.mdata_r; end
            end
            m_pend      = (gc && !s.c_we) || (gh && !s.h_we);
            m_pend_host = gh;
        end
        push_exp(gnt_q, cycle, {39'd0, gc, gh, ev});
        push_exp(cmd_q, cycle + 1, cmd);
        push_exp(ret_q, cycle + 1, {rc, rh, m_c_rdata, m_h_rdata});
    endtask

    task automatic compare(input string name, input logic [41:0] act, input logic [41:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cycle, act, exp);
        end
    endtask

    // Pop every expectation due this cycle and compare against the DUT
    task automatic check_output();
        exp_t e;
        while (gnt_q.size() > 0 && gnt_q[0].cyc <= cycle) begin
            e = gnt_q.pop_front();
            compare("gnt_err", {39'd0, c_gnt, h_gnt, err}, e.val);
        end
        while (cmd_q.size() > 0 && cmd_q[0].cyc <= cycle) begin
            e = cmd_q.pop_front();
            compare("mem_cmd", {mce, mwe, msel, maddr, mdata_w}, e.val);
        end
        while (ret_q.size() > 0 && ret_q[0].cyc <= cycle) begin
            e = ret_q.pop_front();
            compare("read_ret", {c_rvalid, h_rvalid, c_rdata, h_rdata}, e.val);
        end
    endtask

    // Monitor: sample away from the active edge
    always @(negedge clk) check_output();

    initial begin
        stim_t s;
        reset = 1'b1; c_req = 0; c_we = 0; c_sel = 3'b100; c_addr = '0; c_wdata = '0;
        h_req = 0; h_we = 0; h_sel = 3'b100; h_addr = '0; h_wdata = '0; h_lock = 0;
        mdata_r = '0;

        // Reset
        s = idle_stim(); s.reset = 1;
        apply_stimulus(s);
        apply_stimulus(s);

        // Single core read, then known memory data on the following cycle
        s = idle_stim(); s.c_req = 1; s.c_sel = 3'b010; s.c_addr = 17'h00123;
        apply_stimulus(s);
        s = idle_stim(); s.mdata_r = 20'hABCDE;
        apply_stimulus(s);
        apply_stimulus(idle_stim());

        // Both ports reading right after reset: alternating grants
        s = idle_stim(); s.reset = 1;
        apply_stimulus(s);
        for (int i = 0; i < 4; i++) begin
            s = idle_stim();
            s.c_req = 1; s.c_sel = 3'b001; s.c_addr = 17'(i);
            s.h_req = 1; s.h_sel = 3'b011; s.h_addr = 17'(100 + i);
            apply_stimulus(s);
        end
        apply_stimulus(idle_stim());
        apply_stimulus(idle_stim());

        // Locked host write burst against a waiting core
        s = idle_stim(); s.h_req = 1; s.h_we = 1; s.h_sel = 3'b001; s.h_lock = 1;
        apply_stimulus(s);
        for (int i = 0; i < 20; i++) begin
            s = idle_stim();
            s.h_req = 1; s.h_we = 1; s.h_sel = 3'b001; s.h_lock = 1;
            s.h_addr = 17'(i); s.h_wdata = 20'(i * 3);
            s.c_req = 1; s.c_we = 1; s.c_sel = 3'b010; s.c_addr = 17'h1F000;
            apply_stimulus(s);
        end
        apply_stimulus(idle_stim());

        // Host request with the reserved select code
        s = idle_stim(); s.h_req = 1; s.h_sel = 3'b100; s.h_addr = 17'h00777;
        apply_stimulus(s);
        apply_stimulus(idle_stim());

        // Core read cut off by reset on the following cycle
        s = idle_stim(); s.c_req = 1; s.c_sel = 3'b010; s.c_addr = 17'h00055;
        apply_stimulus(s);
        s = idle_stim(); s.reset = 1;
        apply_stimulus(s);
        apply_stimulus(idle_stim());
        apply_stimulus(idle_stim());

        // Host write to select 101
        s = idle_stim(); s.h_req = 1; s.h_we = 1; s.h_sel = 3'b101;
        s.h_addr = 17'h00040; s.h_wdata = 20'h10000;
        apply_stimulus(s);
        apply_stimulus(idle_stim());
        apply_stimulus(idle_stim());

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            s.reset   = ($urandom_range(0, 60) == 0);
            s.c_req   = ($urandom_range(0, 9) < 7);
            s.c_we    = 1'($urandom);
            s.c_sel   = 3'($urandom_range(0, 7));
            s.c_addr  = 17'($urandom);
            s.c_wdata = 20'($urandom);
            s.h_req   = ($urandom_range(0, 9) < 7);
            s.h_we    = 1'($urandom);
            s.h_sel   = 3'($urandom_range(0, 7));
            s.h_addr  = 17'($urandom);
            s.h_wdata = 20'($urandom);
            s.h_lock  = ($urandom_range(0, 3) != 0);
            s.mdata_r = 20'($urandom);
            apply_stimulus(s);
        end

        // Drain
        for (int i = 0; i < 3; i++) apply_stimulus(idle_stim());
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (gnt_q.size() + cmd_q.size() + ret_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain leftover=%0d expected=0", gnt_q.size() + cmd_q.size() + ret_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rnn_mem_arb.md
RNN_MEM_ARB -- requirements
Module: rnn_mem_arb

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 c_req/h_req  input  1  core/host access request, held until granted.
REQ-004 c_we/h_we  input  1  write command (1) or read command (0).
REQ-005 c_sel/h_sel  input  3  memory select; 3'b100 is reserved as the idle code.
REQ-006 c_addr/h_addr  input  17  word address.
REQ-007 c_wdata/h_wdata  input  20  write data.
REQ-008 h_lock  input  1  host requests that consecutive host grants be held as a burst.
REQ-009 c_gnt/h_gnt  output  1  combinational accept, valid in the request cycle.
REQ-010 c_rvalid/h_rvalid  output  1  one-cycle read-return strobe.
REQ-011 c_rdata/h_rdata  output  20  read data, valid when the matching rvalid is high.
REQ-012 err  output  1  one-cycle pulse when a request is refused for carrying sel==3'b100.
REQ-013 mce, mwe  output  1  registered memory enable and write enable.
REQ-014 msel  output  3; maddr  output  17; mdata_w  output  20  registered memory command.
REQ-015 mdata_r  input  20  memory read data, valid one cycle after the command cycle.

Function
REQ-016 At most one gnt shall be high in any cycle; gnt requires the matching req and sel!=3'b100.
REQ-017 A request with sel==3'b100 shall never be granted, shall pulse err, and shall not move the round-robin pointer.
REQ-018 A single valid requester shall be granted in the same cycle.
REQ-019 When both requesters are valid and no lock is active, the requester other than last_winner shall be granted.
REQ-020 last_winner shall update to the granted requester at each grant; its reset value is host, so the core wins the first tie.
REQ-021 Lock state: entered when h_gnt is high with h_lock=1; held while h_req&h_lock; left when either drops.
REQ-022 While the lock is held, core requests shall be refused unless the starvation override applies.
REQ-023 starve_cnt (4 bit) shall increment each cycle c_req is high and not granted, saturate at 15, and clear on c_gnt or when c_req is low.
REQ-024 When starve_cnt==15 and the core is valid, the core shall be granted regardless of lock; the lock shall persist afterwards.
REQ-025 On a grant in cycle T, mce=1 in cycle T+1, with mwe, msel, maddr and mdata_w carrying the granted command.
REQ-026 With no grant, the registered outputs shall take mce=0, mwe=0 and msel=3'b100; maddr and mdata_w hold their previous values.
REQ-027 A granted read shall return rvalid=1 to its owner only, in cycle T+2, with rdata equal to mdata_r sampled at the end of T+1.
REQ-028 The read-return owner tag shall pipeline alongside the command, so back-to-back reads from alternating requesters each return to the correct owner.
REQ-029 rdata shall hold its value between rvalid pulses.
REQ-030 Writes shall produce no rvalid.
REQ-031 Throughput shall be one grant per cycle with no bubbles.

Reset
REQ-032 Reset values: mce=0, mwe=0, msel=3'b100, maddr=0, mdata_w=0, rvalid=0 on both ports, rdata=0 on both ports, err=0, lock=0, starve_cnt=0, last_winner=host, return pipeline empty.
REQ-033 Reset mid-operation shall drop any read in flight with no rvalid issued; grants in the reset cycle shall be 0.

Verification
REQ-034 Core read only: c_req=1, c_we=0, c_sel=3'b010, c_addr=17'h00123 at T -> c_gnt@T; mce=1, msel=010, maddr=123 @T+1; mdata_r=20'hABCDE @T+1 -> c_rvalid=1, c_rdata=ABCDE @T+2.
REQ-035 Simultaneous reads from both requesters for 4 cycles after reset -> grants alternate core, host, core, host; each rvalid returns to its own owner 2 cycles after its grant.
REQ-036 Host write burst with h_lock=1 and c_req held -> host granted for 15 cycles, core granted on the 16th cycle (starve_cnt=15), host resumes on the next cycle.
REQ-037 Host request with h_sel=3'b100 alone -> h_gnt=0, err=1 for that cycle, mce=0 next cycle, last_winner unchanged.
REQ-038 Core read granted at T, reset asserted at T+1 -> no c_rvalid at T+2; all outputs at their reset values from T+2.
REQ-039 Host write h_sel=3'b101, h_addr=17'h00040, h_wdata=20'h10000 -> mwe=1, msel=101, mdata_w=10000 next cycle; no rvalid on either port.
